// File: rtl/circle_raster_if.sv
`default_nettype none
// ============================================================================
// Module      : circle_raster_if
// Description : Request/response and pixel-write bundle for circle_raster.
//               master : drawing requester (drives start/mode/colour/centre/
//                        radius, observes done and the pixel write port)
//               slave  : the rasteriser itself
// Ports       : start, mode, colour, centre_x, centre_y, radius  (req -> eng)
//               done, vga_x, vga_y, vga_colour, vga_plot        (eng -> req)
// Revision    : 1.0 - initial release
// ============================================================================
interface circle_raster_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 8,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic                mode;
    logic [COLOUR_W-1:0] colour;
    logic [X_W:0]        centre_x;
    logic [Y_W:0]        centre_y;
    logic [R_W-1:0]      radius;
    logic                done;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

    modport master (
        output start, mode, colour, centre_x, centre_y, radius,
        input  done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, mode, colour, centre_x, centre_y, radius,
        output done, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface
`default_nettype wire

// File: rtl/circle_raster.sv
`default_nettype none
// ============================================================================
// Module      : circle_raster
// Description : Midpoint-circle rasteriser, outline or filled disc. Emits one
//               candidate pixel per clock into a frame-buffer write port;
//               off-screen candidates keep their cycle but are not plotted.
// Ports       : clk    - system clock
//               rst_n  - asynchronous active-low reset
//               bus    - circle_raster_if.slave (start/done handshake, draw
//                        parameters, registered vga_x/y/colour/plot)
// Revision    : 1.0 - initial release
// ============================================================================
module circle_raster #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int R_W      = 8,
    parameter int COLOUR_W = 3
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    circle_raster_if.slave      bus
);

    // Signed working width: wide enough for centre +/- radius and the
    // decision variable, so no intermediate can wrap.
    localparam int AW = ((X_W > Y_W) ? X_W : Y_W) + (R_W / 2) + 4;

    localparam logic signed [AW-1:0] c_zero  = '0;
    localparam logic signed [AW-1:0] c_one   = AW'(1);
    localparam logic signed [AW-1:0] c_scr_w = AW'(SCREEN_W);
    localparam logic signed [AW-1:0] c_scr_h = AW'(SCREEN_H);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_PLOT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_mode;
    logic [COLOUR_W-1:0]    r_colour;
    logic [R_W-1:0]         r_radius;
    logic signed [AW-1:0]   r_cx;
    logic signed [AW-1:0]   r_cy;
    logic signed [AW-1:0]   r_ox;
    logic signed [AW-1:0]   r_oy;
    logic signed [AW-1:0]   r_crit;
    logic signed [AW-1:0]   r_dx;     // filled mode: x offset within span
    logic [2:0]             r_sub;    // outline mode: octant index
    logic [1:0]             r_span;   // filled mode: span index

    logic                   r_done;
    logic [X_W-1:0]         r_vga_x;
    logic [Y_W-1:0]         r_vga_y;
    logic [COLOUR_W-1:0]    r_vga_colour;
    logic                   r_vga_plot;

    logic signed [AW-1:0]   w_oy_n;
    logic signed [AW-1:0]   w_ox_n;
    logic signed [AW-1:0]   w_crit_n;
    logic signed [AW-1:0]   w_half;
    logic signed [AW-1:0]   w_cand_x;
    logic signed [AW-1:0]   w_cand_y;
    logic                   w_last;
    logic                   w_on_screen;

    // Midpoint step taken at the end of each iteration; the updated oy/ox
    // feed the decision-variable update.
    always_comb begin
        w_oy_n   = r_oy + c_one;
        w_ox_n   = r_ox;
        w_crit_n = r_crit + (w_oy_n <<< 1) + c_one;
        if (r_crit > c_zero) begin
            w_ox_n   = r_ox - c_one;
            w_crit_n = r_crit + ((w_oy_n - w_ox_n) <<< 1) + c_one;
        end
    end

    // Current candidate pixel and whether it closes the iteration.
    always_comb begin
        // Spans 0/1 lie on rows cy+-oy (half width ox); spans 2/3 on rows
        // cy+-ox (half width oy).
        w_half   = r_span[1] ? r_oy : r_ox;
        w_cand_x = r_cx + r_dx;
        w_cand_y = r_cy;
        w_last   = 1'b0;
        if (r_mode) begin
            case (r_span)
                2'd0:    w_cand_y = r_cy + r_oy;
                2'd1:    w_cand_y = r_cy - r_oy;
                2'd2:    w_cand_y = r_cy + r_ox;
                default: w_cand_y = r_cy - r_ox;
            endcase
            w_last = (r_span == 2'd3) && (r_dx == w_half);
        end else begin
            case (r_sub)
                3'd0: begin w_cand_x = r_cx + r_ox; w_cand_y = r_cy + r_oy; end
                3'd1: begin w_cand_x = r_cx + r_oy; w_cand_y = r_cy + r_ox; end
                3'd2: begin w_cand_x = r_cx - r_oy; w_cand_y = r_cy + r_ox; end
                3'd3: begin w_cand_x = r_cx - r_ox; w_cand_y = r_cy + r_oy; end
                3'd4: begin w_cand_x = r_cx - r_ox; w_cand_y = r_cy - r_oy; end
                3'd5: begin w_cand_x = r_cx - r_oy; w_cand_y = r_cy - r_ox; end
                3'd6: begin w_cand_x = r_cx + r_oy; w_cand_y = r_cy - r_ox; end
                default: begin w_cand_x = r_cx + r_ox; w_cand_y = r_cy - r_oy; end
            endcase
            w_last = (r_sub == 3'd7);
        end
        w_on_screen = (w_cand_x >= c_zero) && (w_cand_x < c_scr_w) &&
                      (w_cand_y >= c_zero) && (w_cand_y < c_scr_h);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mode       <= 1'b0;
            r_colour     <= '0;
            r_radius     <= '0;
            r_cx         <= c_zero;
            r_cy         <= c_zero;
            r_ox         <= c_zero;
            r_oy         <= c_zero;
            r_crit       <= c_zero;
            r_dx         <= c_zero;
            r_sub        <= 3'd0;
            r_span       <= 2'd0;
            r_done       <= 1'b0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_vga_plot <= 1'b0;
                    r_done     <= 1'b0;
                    if (bus.start) begin
                        r_mode   <= bus.mode;
                        r_colour <= bus.colour;
                        r_radius <= bus.radius;
                        r_cx     <= AW'(bus.centre_x);
                        r_cy     <= AW'(bus.centre_y);
                        r_state  <= S_INIT;
                    end
                end

                S_INIT: begin
                    r_vga_plot <= 1'b0;
                    r_ox       <= AW'(r_radius);
                    r_oy       <= c_zero;
                    r_crit     <= c_one - AW'(r_radius);
                    r_dx       <= c_zero - AW'(r_radius);
                    r_sub      <= 3'd0;
                    r_span     <= 2'd0;
                    r_state    <= S_PLOT;
                end

                S_PLOT: begin
                    // Candidate is registered regardless of clipping so the
                    // cycle count is independent of screen position.
                    r_vga_x      <= w_cand_x[X_W-1:0];
                    r_vga_y      <= w_cand_y[Y_W-1:0];
                    r_vga_colour <= r_colour;
                    r_vga_plot   <= w_on_screen;
                    if (w_last) begin
                        if (w_oy_n <= w_ox_n) begin
                            r_ox   <= w_ox_n;
                            r_oy   <= w_oy_n;
                            r_crit <= w_crit_n;
                            r_sub  <= 3'd0;
                            r_span <= 2'd0;
                            r_dx   <= -w_ox_n;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else if (!r_mode) begin
                        r_sub <= r_sub + 3'd1;
                    end else if (r_dx == w_half) begin
                        // Next span starts at minus its own half width.
                        r_span <= r_span + 2'd1;
                        r_dx   <= (r_span == 2'd0) ? -r_ox : -r_oy;
                    end else begin
                        r_dx <= r_dx + c_one;
                    end
                end

                default: begin  // S_DONE
                    r_vga_plot <= 1'b0;
                    if (r_done && !bus.start) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.done       = r_done;
    assign bus.vga_x      = r_vga_x;
    assign bus.vga_y      = r_vga_y;
    assign bus.vga_colour = r_vga_colour;
    assign bus.vga_plot   = r_vga_plot;

endmodule
`default_nettype wire

// File: tb/tb_circle_raster.sv
`default_nettype none
// ============================================================================
// Module      : tb_circle_raster
// Description : Self-checking bench for circle_raster. A reference model
//               expands the midpoint iterations into the expected candidate
//               list; each candidate cycle is compared against it, and
//               hand-derived literals pin the model on small cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_circle_raster;
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int R_W = 8;
    localparam int CW  = 3;
    localparam int SW  = 160;
    localparam int SH  = 120;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    circle_raster_if #(.X_W(X_W), .Y_W(Y_W), .R_W(R_W), .COLOUR_W(CW)) bus ();

    circle_raster #(
        .SCREEN_W(SW), .SCREEN_H(SH), .X_W(X_W), .Y_W(Y_W), .R_W(R_W), .COLOUR_W(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    int ex[$];
    int ey[$];
    bit ep[$];
    int cap_x[$];
    int cap_y[$];
    bit cap_p[$];
    bit hit[SW][SH];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic push_cand(input int x, input int y);
        ex.push_back(x);
        ey.push_back(y);
        ep.push_back((x >= 0) && (x < SW) && (y >= 0) && (y < SH));
    endtask

    // Expected candidate sequence straight from the drawing rules.
    task automatic build_model(input bit md, input int cx, input int cy, input int r);
        int ox, oy, crit;
        ex.delete(); ey.delete(); ep.delete();
        ox = r; oy = 0; crit = 1 - r;
        while (oy <= ox) begin
            if (!md) begin
                push_cand(cx + ox, cy + oy); push_cand(cx + oy, cy + ox);
                push_cand(cx - oy, cy + ox); push_cand(cx - ox, cy + oy);
                push_cand(cx - ox, cy - oy); push_cand(cx - oy, cy - ox);
                push_cand(cx + oy, cy - ox); push_cand(cx + ox, cy - oy);
            end else begin
                for (int x = cx - ox; x <= cx + ox; x++) push_cand(x, cy + oy);
                for (int x = cx - ox; x <= cx + ox; x++) push_cand(x, cy - oy);
                for (int x = cx - oy; x <= cx + oy; x++) push_cand(x, cy + ox);
                for (int x = cx - oy; x <= cx + oy; x++) push_cand(x, cy - ox);
            end
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end
    endtask

    task automatic run_draw(input bit md, input logic [CW-1:0] col,
                            input int cx, input int cy, input int r, input string nm);
        build_model(md, cx, cy, r);
        cap_x.delete(); cap_y.delete(); cap_p.delete();
        for (int i = 0; i < SW; i++) for (int j = 0; j < SH; j++) hit[i][j] = 1'b0;
        @(negedge clk);
        bus.mode     = md;
        bus.colour   = col;
        bus.centre_x = (X_W + 1)'(cx);
        bus.centre_y = (Y_W + 1)'(cy);
        bus.radius   = R_W'(r);
        bus.start    = 1'b1;
        @(posedge clk);                      // edge k: request latched
        @(negedge clk);                      // later changes must be ignored
        bus.colour   = ~col;
        bus.radius   = bus.radius + 8'd3;
        bus.centre_x = bus.centre_x + 9'd7;
        bus.mode     = ~md;
        @(posedge clk);                      // edge k+1
        for (int n = 0; n < ex.size(); n++) begin
            @(posedge clk); #1;              // after edge k+2+n
            cap_x.push_back(int'(bus.vga_x));
            cap_y.push_back(int'(bus.vga_y));
            cap_p.push_back(bus.vga_plot);
            if (bus.vga_plot && int'(bus.vga_x) < SW && int'(bus.vga_y) < SH)
                hit[bus.vga_x][bus.vga_y] = 1'b1;
            checks++;
            if (bus.done !== 1'b0 || bus.vga_plot !== ep[n] ||
                (ep[n] && (int'(bus.vga_x) != ex[n] || int'(bus.vga_y) != ey[n] ||
                           bus.vga_colour !== col))) begin
                failures++;
                $display("FAIL %s cand%0d actual plot=%0b x=%0d y=%0d c=%0d done=%0b required plot=%0b x=%0d y=%0d c=%0d done=0",
                         nm, n, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour, bus.done,
                         ep[n], ex[n], ey[n], col);
            end
        end
        @(posedge clk); #1;                  // after edge k+2+P
        chk({nm, "_done_rise"}, int'(bus.done), 1);
        chk({nm, "_plot_after"}, int'(bus.vga_plot), 0);
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_done_held"}, int'(bus.done), 1);
        chk({nm, "_no_replot"}, int'(bus.vga_plot), 0);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_done_fall"}, int'(bus.done), 0);
        @(posedge clk);
    endtask

    initial begin
        int lx[8];
        int ly[8];
        int cnt;
        int bad;
        bus.start = 1'b0; bus.mode = 1'b0; bus.colour = '0;
        bus.centre_x = '0; bus.centre_y = '0; bus.radius = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_done", int'(bus.done), 0);
        chk("reset_plot", int'(bus.vga_plot), 0);
        chk("reset_xyc", int'(bus.vga_x) + int'(bus.vga_y) + int'(bus.vga_colour), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Outline r=0: eight plots at the centre, done after edge k+10.
        run_draw(1'b0, 3'b010, 80, 60, 0, "out_r0");
        chk("out_r0_count", cap_x.size(), 8);
        bad = 0;
        for (int i = 0; i < cap_x.size(); i++)
            if (cap_x[i] != 80 || cap_y[i] != 60 || !cap_p[i]) bad++;
        chk("out_r0_centre", bad, 0);

        // Outline r=1: two iterations, literal order of iteration 1.
        run_draw(1'b0, 3'b010, 80, 60, 1, "out_r1");
        chk("out_r1_count", cap_x.size(), 16);
        lx = '{81, 81, 79, 79, 79, 79, 81, 81};
        ly = '{61, 61, 61, 61, 59, 59, 59, 59};
        bad = 0;
        for (int j = 0; j < 8; j++)
            if (cap_x.size() == 16 && (cap_x[8+j] != lx[j] || cap_y[8+j] != ly[j])) bad++;
        chk("out_r1_iter1_order", bad, 0);

        // Redraw with a new colour after the handshake.
        run_draw(1'b0, 3'b101, 80, 60, 1, "out_r1_recol");

        // Outline r=5 near the left edge: 32 candidates, 10 clipped (x<0).
        run_draw(1'b0, 3'b111, 2, 60, 5, "out_r5_clip");
        chk("out_r5_clip_count", cap_x.size(), 32);
        cnt = 0; bad = 0;
        for (int i = 0; i < cap_p.size(); i++) begin
            int d2;
            if (!cap_p[i]) cnt++;
            else begin
                d2 = (cap_x[i] - 2) * (cap_x[i] - 2) + (cap_y[i] - 60) * (cap_y[i] - 60);
                if (d2 < 20 || d2 > 30) bad++;
            end
        end
        chk("out_r5_clipped", cnt, 10);
        chk("out_r5_radius_band", bad, 0);

        // Same radius on-screen: same 32-candidate length, all plotted.
        run_draw(1'b0, 3'b001, 80, 60, 5, "out_r5");
        cnt = 0;
        for (int i = 0; i < cap_p.size(); i++) if (cap_p[i]) cnt++;
        chk("out_r5_plots", cnt, 32);

        // Filled r=0: four plots at centre, done after edge k+6.
        run_draw(1'b1, 3'b100, 80, 60, 0, "fill_r0");
        chk("fill_r0_count", cap_x.size(), 4);
        bad = 0;
        for (int i = 0; i < cap_x.size(); i++)
            if (cap_x[i] != 80 || cap_y[i] != 60 || !cap_p[i]) bad++;
        chk("fill_r0_centre", bad, 0);

        // Filled r=3: interior covered, nothing beyond radius+1.
        run_draw(1'b1, 3'b011, 80, 60, 3, "fill_r3");
        bad = 0; cnt = 0;
        for (int dx = -5; dx <= 5; dx++)
            for (int dy = -5; dy <= 5; dy++) begin
                if (dx * dx + dy * dy <= 12 && !hit[80+dx][60+dy]) bad++;
                if (dx * dx + dy * dy > 16 && hit[80+dx][60+dy]) cnt++;
            end
        chk("fill_r3_covered", bad, 0);
        chk("fill_r3_outside", cnt, 0);

        // Filled disc clipped at the top-left corner.
        run_draw(1'b1, 3'b110, 0, 0, 2, "fill_corner");

        // Reset mid-draw at candidate 5, then a fresh full draw.
        @(negedge clk);
        bus.mode = 1'b0; bus.colour = 3'b010; bus.centre_x = 9'd80;
        bus.centre_y = 8'd60; bus.radius = 8'd5; bus.start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_cand5_plot", int'(bus.vga_plot), 1);
        chk("mid_cand5_x", int'(bus.vga_x), 80);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_plot", int'(bus.vga_plot), 0);
        chk("mid_reset_done", int'(bus.done), 0);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_draw(1'b0, 3'b010, 80, 60, 5, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog: the whole sequence is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
